alu: RTL and testbench

- 32-bit combinational-decode, registered-output integer ALU for the datapath execute stage.
- Six discrete select lines choose the operation:
  - logic: AND, OR, XOR
  - shifts: SLL, SRA, SRL
  - arithmetic: ADD, SUB
  - set-on-compare: SEQ, SNE, SLT, SGT, SLE, SGE
- The result is captured in an output register each clock.

---
 rtl/alu.sv | 85 ++++++++
 tb/tb_alu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered-output integer ALU for the execute stage: the opcode on the six select
// lines is decoded combinationally and the chosen result is captured every clock.
module alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             sel0,
   input  logic             sel1,
   input  logic             sel2,
   input  logic             sel3,
   input  logic             sel4,
   input  logic             sel5,
   output logic [WIDTH-1:0] out
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [5:0] {
      OP_AND = 6'b000000,
      OP_OR  = 6'b000001,
      OP_XOR = 6'b000010,
      OP_SLL = 6'b000110,
      OP_SRA = 6'b000100,
      OP_SRL = 6'b000101,
      OP_ADD = 6'b100000,
      OP_SUB = 6'b111000,
      OP_SEQ = 6'b110000,
      OP_SNE = 6'b110001,
      OP_SLT = 6'b110010,
      OP_SGT = 6'b110011,
      OP_SLE = 6'b110100,
      OP_SGE = 6'b110110
   } op_e;

   logic [5:0]       op;
   logic [SHW-1:0]   amount;
   logic             cond;
   logic [WIDTH-1:0] result;

   assign op     = {sel5, sel4, sel3, sel2, sel1, sel0};
   assign amount = in2[SHW-1:0];

   // Set-on-compare condition; ordering compares are two's-complement signed
   always_comb begin
      cond = 1'b0;
      case (op)
         OP_SEQ:  cond = (in1 == in2);
         OP_SNE:  cond = (in1 != in2);
         OP_SLT:  cond = ($signed(in1) <  $signed(in2));
         OP_SGT:  cond = ($signed(in1) >  $signed(in2));
         OP_SLE:  cond = ($signed(in1) <= $signed(in2));
         OP_SGE:  cond = ($signed(in1) >= $signed(in2));
         default: cond = 1'b0;
      endcase
   end

   // Unlisted opcodes fall through to zero rather than holding the last result
   always_comb begin
      result = '0;
      case (op)
         OP_AND:  result = in1 & in2;
         OP_OR:   result = in1 | in2;
         OP_XOR:  result = in1 ^ in2;
         OP_SLL:  result = in1 << amount;
         OP_SRA:  result = $unsigned($signed(in1) >>> amount);
         OP_SRL:  result = in1 >> amount;
         OP_ADD:  result = in1 + in2;
         OP_SUB:  result = in1 - in2;
         OP_SEQ, OP_SNE, OP_SLT, OP_SGT, OP_SLE, OP_SGE:
                  result = {{(WIDTH-1){1'b0}}, cond};
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         out <= '0;
      else
         out <= result;
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed boundary cases followed by randomized
// back-to-back operations compared against an arithmetic reference model.
module tb_alu;

   localparam logic [5:0] AND_OP = 6'b000000;
   localparam logic [5:0] OR_OP  = 6'b000001;
   localparam logic [5:0] XOR_OP = 6'b000010;
   localparam logic [5:0] SLL_OP = 6'b000110;
   localparam logic [5:0] SRA_OP = 6'b000100;
   localparam logic [5:0] SRL_OP = 6'b000101;
   localparam logic [5:0] ADD_OP = 6'b100000;
   localparam logic [5:0] SUB_OP = 6'b111000;
   localparam logic [5:0] SEQ_OP = 6'b110000;
   localparam logic [5:0] SNE_OP = 6'b110001;
   localparam logic [5:0] SLT_OP = 6'b110010;
   localparam logic [5:0] SGT_OP = 6'b110011;
   localparam logic [5:0] SLE_OP = 6'b110100;
   localparam logic [5:0] SGE_OP = 6'b110110;

   logic        clk;
   logic        rst;
   logic [31:0] in1;
   logic [31:0] in2;
   logic [5:0]  op;
   logic [31:0] out;

   int vectorCount = 0;
   int missCount   = 0;

   logic [5:0]  legalOps [14] = '{AND_OP, OR_OP, XOR_OP, SLL_OP, SRA_OP, SRL_OP, ADD_OP,
                                  SUB_OP, SEQ_OP, SNE_OP, SLT_OP, SGT_OP, SLE_OP, SGE_OP};
   logic [31:0] edgeVals [8]  = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'd42, 32'h0000_001F, 32'hFFFF_FFE3};

   alu #(.WIDTH(32)) dut (
      .clk  (clk),
      .rst  (rst),
      .in1  (in1),
      .in2  (in2),
      .sel0 (op[0]),
      .sel1 (op[1]),
      .sel2 (op[2]),
      .sel3 (op[3]),
      .sel4 (op[4]),
      .sel5 (op[5]),
      .out  (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour from plain arithmetic: shifts as multiply/divide by a power
   // of two, signed right shift as floor division, compares on sign-extended values
   function automatic logic [31:0] refModel(input logic [5:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
      longint      ua = longint'(a);
      longint      ub = longint'(b);
      longint      sa = longint'($signed(a));
      longint      sb = longint'($signed(b));
      int unsigned sh = {27'd0, b[4:0]};
      longint      p  = longint'(1) << sh;
      case (o)
         AND_OP: return a & b;
         OR_OP:  return a | b;
         XOR_OP: return a ^ b;
         SLL_OP: return 32'(ua * p);
         SRL_OP: return 32'(ua / p);
         SRA_OP: return (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
         ADD_OP: return 32'(ua + ub);
         SUB_OP: return 32'(ua - ub);
         SEQ_OP: return (sa == sb) ? 32'd1 : 32'd0;
         SNE_OP: return (sa != sb) ? 32'd1 : 32'd0;
         SLT_OP: return (sa <  sb) ? 32'd1 : 32'd0;
         SGT_OP: return (sa >  sb) ? 32'd1 : 32'd0;
         SLE_OP: return (sa <= sb) ? 32'd1 : 32'd0;
         SGE_OP: return (sa >= sb) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drives one operation at the falling edge and checks it one rising edge later
   task automatic applyStimulus(input string tag, input logic [5:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expected);
      @(negedge clk);
      op  = o;
      in1 = a;
      in2 = b;
      @(posedge clk);
      #1;
      checkOutput(tag, out, expected);
   endtask

   initial begin
      logic [5:0]  rOp;
      logic [31:0] rA, rB, prevExp, curExp;

      rst = 1'b1; op = ADD_OP; in1 = 32'd5; in2 = 32'd7;
      @(posedge clk); #1;
      checkOutput("reset", out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("add_after_reset", out, 32'd12);

      applyStimulus("and",  AND_OP, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
      applyStimulus("or",   OR_OP,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
      applyStimulus("xor",  XOR_OP, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
      applyStimulus("sll",  SLL_OP, 32'h8000_0010, 32'd4, 32'h0000_0100);
      applyStimulus("srl",  SRL_OP, 32'h8000_0010, 32'd4, 32'h0800_0001);
      applyStimulus("sra",  SRA_OP, 32'h8000_0010, 32'd4, 32'hF800_0001);
      applyStimulus("sll_hi_ignored", SLL_OP, 32'h8000_0010, 32'hFFFF_FFE3, 32'h0000_0080);
      applyStimulus("sra_31", SRA_OP, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
      applyStimulus("sll_0",  SLL_OP, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF);
      applyStimulus("add_wrap", ADD_OP, 32'hFFFF_FFFF, 32'd1, 32'd0);
      applyStimulus("sub_3_5",  SUB_OP, 32'd3, 32'd5, 32'hFFFF_FFFE);
      applyStimulus("sub_0_1",  SUB_OP, 32'd0, 32'd1, 32'hFFFF_FFFF);
      applyStimulus("add_123",  ADD_OP, 32'd100, 32'd23, 32'd123);
      applyStimulus("slt_neg", SLT_OP, 32'h8000_0000, 32'd1, 32'd1);
      applyStimulus("sgt_neg", SGT_OP, 32'h8000_0000, 32'd1, 32'd0);
      applyStimulus("sle_neg", SLE_OP, 32'h8000_0000, 32'd1, 32'd1);
      applyStimulus("sge_neg", SGE_OP, 32'h8000_0000, 32'd1, 32'd0);
      applyStimulus("seq_neg", SEQ_OP, 32'h8000_0000, 32'd1, 32'd0);
      applyStimulus("sne_neg", SNE_OP, 32'h8000_0000, 32'd1, 32'd1);
      applyStimulus("seq_eq", SEQ_OP, 32'd42, 32'd42, 32'd1);
      applyStimulus("sne_eq", SNE_OP, 32'd42, 32'd42, 32'd0);
      applyStimulus("sle_eq", SLE_OP, 32'd42, 32'd42, 32'd1);
      applyStimulus("sge_eq", SGE_OP, 32'd42, 32'd42, 32'd1);
      applyStimulus("slt_eq", SLT_OP, 32'd42, 32'd42, 32'd0);
      applyStimulus("sgt_eq", SGT_OP, 32'd42, 32'd42, 32'd0);
      applyStimulus("illegal", 6'b111111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

      // Random back-to-back ops; out must still show the previous result just before the edge
      prevExp = 32'd0;
      for (int i = 0; i < 300; i++) begin
         rOp = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legalOps[$urandom_range(0, 13)];
         rA  = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 7)] : $urandom;
         rB  = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 7)] : $urandom;
         if ($urandom_range(0, 7) == 0) rB = rA;
         curExp = refModel(rOp, rA, rB);
         @(negedge clk);
         op = rOp; in1 = rA; in2 = rB;
         #1;
         if (i > 0) checkOutput("rand_hold", out, prevExp);
         @(posedge clk); #1;
         checkOutput($sformatf("rand_op%b", rOp), out, curExp);
         prevExp = curExp;
      end

      @(negedge clk);
      rst = 1'b1; op = ADD_OP; in1 = 32'd1; in2 = 32'd1;
      @(posedge clk); #1;
      checkOutput("reset_priority", out, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
